// File: rtl/maze_solver_dfs.sv
// maze_solver_dfs: depth-first maze solver with a direction stack, overflow detection and path replay
module maze_solver_dfs #(
  parameter int XW = 4,
  parameter int YW = 4,
  parameter int XMAX = 15,
  parameter int YMAX = 15,
  parameter int DEPTH = 256,
  parameter int PW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] goal_x,
  input  logic [YW-1:0] goal_y,
  input  logic          run,
  input  logic          dout,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          wr,
  output logic          done,
  output logic          fail,
  output logic          overflow,
  output logic [1:0]    move,
  output logic          move_valid,
  output logic [PW-1:0] path_len
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [XW-1:0] XM = XW'(XMAX);
  localparam logic [YW-1:0] YM = YW'(YMAX);
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  typedef enum logic [2:0] {IDLE, INIT, PROBE, BACK, DONE, REPLAY, FAIL} state_t;
  state_t state, state_n;
  logic [XW-1:0] cur_x, cur_x_n, gx, gx_n, nx, bx;
  logic [YW-1:0] cur_y, cur_y_n, gy, gy_n, ny, by;
  logic [1:0] d, d_n, top;
  logic [PW-1:0] sp, sp_n, r, r_n;
  logic ovf, ovf_n, push, inb, free;
  logic [1:0] stack [DEPTH];
  assign top = stack[AW'(sp - 1'b1)];
  assign nx = d == 2'd1 ? cur_x + 1'b1 : d == 2'd2 ? cur_x - 1'b1 : cur_x;
  assign ny = d == 2'd0 ? cur_y - 1'b1 : d == 2'd3 ? cur_y + 1'b1 : cur_y;
  // Out-of-bounds neighbours count as walls without consulting the memory
  assign inb = d == 2'd0 ? cur_y != '0 : d == 2'd1 ? cur_x != XM : d == 2'd2 ? cur_x != '0 : cur_y != YM;
  assign free = inb && !dout;
  assign bx = top == 2'd1 ? cur_x - 1'b1 : top == 2'd2 ? cur_x + 1'b1 : cur_x;
  assign by = top == 2'd0 ? cur_y + 1'b1 : top == 2'd3 ? cur_y - 1'b1 : cur_y;
  always_comb begin
    state_n = state;
    cur_x_n = cur_x;
    cur_y_n = cur_y;
    d_n = d;
    sp_n = sp;
    r_n = r;
    gx_n = gx;
    gy_n = gy;
    ovf_n = ovf;
    push = 1'b0;
    wr = 1'b0;
    x = cur_x;
    y = cur_y;
    case (state)
      IDLE, DONE, FAIL: begin
        if (state == IDLE) begin
          x = '0;
          y = '0;
        end
        if (state == DONE && run) begin
          r_n = '0;
          state_n = REPLAY;
        end else if (start) begin
          gx_n = goal_x;
          gy_n = goal_y;
          cur_x_n = '0;
          cur_y_n = '0;
          sp_n = '0;
          d_n = '0;
          ovf_n = 1'b0;
          state_n = INIT;
        end
      end
      INIT: begin
        if (dout) state_n = FAIL;
        else begin
          wr = 1'b1;
          state_n = (gx == '0 && gy == '0) ? DONE : PROBE;
        end
      end
      PROBE: begin
        x = nx;
        y = ny;
        if (free && sp == FULL) begin
          ovf_n = 1'b1;
          state_n = FAIL;
        end else if (free) begin
          wr = 1'b1;
          push = 1'b1;
          sp_n = sp + 1'b1;
          cur_x_n = nx;
          cur_y_n = ny;
          d_n = '0;
          if (nx == gx && ny == gy) state_n = DONE;
        end else if (d != 2'd3) d_n = d + 1'b1;
        else state_n = BACK;
      end
      BACK: begin
        if (sp == '0) state_n = FAIL;
        else begin
          sp_n = sp - 1'b1;
          cur_x_n = bx;
          cur_y_n = by;
          if (top != 2'd3) begin
            d_n = top + 1'b1;
            state_n = PROBE;
          end
        end
      end
      REPLAY: begin
        r_n = r + 1'b1;
        if (sp == '0 || r == sp - 1'b1) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur_x <= '0;
      cur_y <= '0;
      gx <= '0;
      gy <= '0;
      d <= '0;
      sp <= '0;
      r <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      cur_x <= cur_x_n;
      cur_y <= cur_y_n;
      gx <= gx_n;
      gy <= gy_n;
      d <= d_n;
      sp <= sp_n;
      r <= r_n;
      ovf <= ovf_n;
    end
  end
  always_ff @(posedge clk) begin
    if (push) stack[AW'(sp)] <= d;
  end
  assign done = state == DONE || state == REPLAY;
  assign fail = state == FAIL;
  assign overflow = ovf;
  assign move_valid = state == REPLAY && sp != '0;
  assign move = move_valid ? stack[AW'(r)] : 2'b00;
  assign path_len = sp;
endmodule

// File: tb/tb_maze_solver_dfs.sv
// tb_maze_solver_dfs: directed and randomized 4x4 maze solves against a queue-based DFS reference
module tb_maze_solver_dfs;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0, run = 1'b0, load = 1'b0;
  logic [1:0] gx = '0, gy = '0;
  logic [15:0] walls = '0, mem, mem2;
  logic [1:0] x, y, x2, y2, move, move2;
  logic wr, done, fail, overflow, move_valid, wr2, done2, fail2, overflow2, move_valid2;
  logic [4:0] path_len;
  logic [1:0] path_len2;
  int wcnt;
  int checks = 0, errors = 0;

  maze_solver_dfs #(.XW(2), .YW(2), .XMAX(3), .YMAX(3), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .goal_x(gx), .goal_y(gy), .run(run),
    .dout(mem[{y, x}]), .x(x), .y(y), .wr(wr), .done(done), .fail(fail),
    .overflow(overflow), .move(move), .move_valid(move_valid), .path_len(path_len));

  maze_solver_dfs #(.XW(2), .YW(2), .XMAX(3), .YMAX(3), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .goal_x(gx), .goal_y(gy), .run(1'b0),
    .dout(mem2[{y2, x2}]), .x(x2), .y(y2), .wr(wr2), .done(done2), .fail(fail2),
    .overflow(overflow2), .move(move2), .move_valid(move_valid2), .path_len(path_len2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      mem <= walls;
      mem2 <= walls;
      wcnt <= 0;
    end else begin
      if (wr) begin
        mem[{y, x}] <= 1'b1;
        wcnt <= wcnt + 1;
      end
      if (wr2) mem2[{y2, x2}] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prep(input logic [15:0] w);
    walls = w;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic start_solve(input int gxx, input int gyy);
    gx = 2'(gxx);
    gy = 2'(gyy);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end();
    for (int n = 0; n < 400 && !(done || fail); n++) tick();
  endtask

  // run and start together: run must win, so the replay must still be intact
  task automatic do_replay(output logic [31:0] got, output int cnt);
    got = 0;
    cnt = 0;
    run = 1'b1;
    start = 1'b1;
    tick();
    run = 1'b0;
    start = 1'b0;
    for (int n = 0; n < 40 && move_valid; n++) begin
      got = (got << 2) | 32'(move);
      cnt++;
      tick();
    end
  endtask

  // res: 0 solved, 1 no path, 2 stack overflow
  function automatic void model(input logic [15:0] w, input int gxx, input int gyy, input int depth,
                                output int res, output int len, output logic [31:0] mv,
                                output int wrs, output logic [15:0] vis);
    int dxs[4] = '{0, 1, -1, 0};
    int dys[4] = '{-1, 0, 0, 1};
    int path[$];
    int cx, cy, nx, ny, dd, d, p;
    res = 1;
    len = 0;
    mv = 0;
    wrs = 0;
    vis = w;
    if (vis[0]) return;
    vis[0] = 1'b1;
    wrs = 1;
    if (gxx == 0 && gyy == 0) begin
      res = 0;
      return;
    end
    cx = 0;
    cy = 0;
    d = 0;
    for (int guard = 0; guard < 2000; guard++) begin
      dd = d;
      nx = 0;
      ny = 0;
      while (dd < 4) begin
        nx = cx + dxs[dd];
        ny = cy + dys[dd];
        if (nx >= 0 && nx <= 3 && ny >= 0 && ny <= 3 && !vis[ny * 4 + nx]) break;
        dd++;
      end
      if (dd < 4) begin
        if (path.size() == depth) begin
          res = 2;
          break;
        end
        vis[ny * 4 + nx] = 1'b1;
        wrs++;
        path.push_back(dd);
        cx = nx;
        cy = ny;
        d = 0;
        if (cx == gxx && cy == gyy) begin
          res = 0;
          break;
        end
      end else begin
        if (path.size() == 0) begin
          res = 1;
          break;
        end
        p = path.pop_back();
        cx -= dxs[p];
        cy -= dys[p];
        d = p + 1;
      end
    end
    len = path.size();
    foreach (path[i]) mv = (mv << 2) | 32'(path[i]);
  endfunction

  task automatic run_case(input string tag, input logic [15:0] w, input int gxx, input int gyy);
    int res, len, wrs, cnt;
    logic [31:0] mv, got;
    logic [15:0] vexp;
    model(w, gxx, gyy, 16, res, len, mv, wrs, vexp);
    prep(w);
    start_solve(gxx, gyy);
    wait_end();
    check({tag, " status"}, {done, fail, overflow}, res == 0 ? 3'b100 : res == 1 ? 3'b010 : 3'b011);
    check({tag, " path_len"}, path_len, len);
    check({tag, " wr_count"}, wcnt, wrs);
    check({tag, " memory"}, mem, vexp);
    if (done) begin
      do_replay(got, cnt);
      check({tag, " replay_count"}, cnt, len);
      check({tag, " replay_moves"}, got, mv);
      check({tag, " done_after_replay"}, {done, move_valid}, 2'b10);
    end
  endtask

  initial begin
    logic [31:0] got;
    int cnt;
    #2;
    check("reset_outputs", {x, y, wr, done, fail, overflow, move, move_valid, path_len}, 0);
    #10 rst = 1'b0;

    prep(16'h0000);
    start_solve(3, 3);
    tick();
    tick();
    tick();
    check("pre_reset_path_len", path_len, 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {x, y, wr, done, fail, overflow, move, move_valid, path_len}, 0);
    #3 rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("idle_hold_outputs", {x, y, wr, done, fail, overflow, move, move_valid, path_len}, 0);

    prep(16'h0000);
    start_solve(3, 0);
    for (int i = 0; i < 6; i++) tick();
    check("open_done_E6", done, 1'b0);
    tick();
    check("open_done_E7", {done, fail, overflow}, 3'b100);
    check("open_path_len", path_len, 3);
    check("open_wr_count", wcnt, 4);
    check("open_memory", mem, 16'h000F);
    do_replay(got, cnt);
    check("open_replay_count", cnt, 3);
    check("open_replay_moves", got, 32'h15);

    prep(16'h0000);
    start_solve(0, 0);
    check("restart_init_not_done", done, 1'b0);
    tick();
    check("restart_goal00_done", {done, path_len}, {1'b1, 5'd0});
    do_replay(got, cnt);
    check("goal00_replay_empty", cnt, 0);

    prep(16'h0012);
    start_solve(3, 3);
    wait_end();
    check("walled_status", {done, fail, overflow}, 3'b010);
    check("walled_path_len", path_len, 0);
    check("walled_wr_count", wcnt, 1);

    prep(16'h0222);
    start_solve(2, 0);
    wait_end();
    check("back_status", {done, fail}, 2'b10);
    check("back_path_len", path_len, 8);
    do_replay(got, cnt);
    check("back_replay_count", cnt, 8);
    check("back_replay_moves", got, 32'hFD40);

    prep(16'h0000);
    gx = 2'd3;
    gy = 2'd3;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 0; n < 100 && !(done2 || fail2); n++) tick();
    check("ovf_status", {done2, fail2, overflow2}, 3'b011);
    check("ovf_path_len", path_len2, 2);
    check("ovf_memory", mem2, 16'h0007);
    prep(16'h0000);
    gx = 2'd1;
    gy = 2'd0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 0; n < 100 && !(done2 || fail2); n++) tick();
    check("ovf_restart_status", {done2, fail2, overflow2}, 3'b100);
    check("ovf_restart_path_len", path_len2, 1);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] w;
      w = 16'($urandom_range(0, 65535) & $urandom_range(0, 65535));
      if (i % 5 != 0) w[0] = 1'b0;
      run_case($sformatf("rand%0d", i), w, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/maze_solver_dfs.md
# maze_solver_dfs

Parametrised depth-first maze solver. Explores a rectangular grid held in an external 1-bit-per-cell maze memory, starting at (0,0) and stopping at a run-time goal cell. Marks visited cells through a write strobe and records the path on an internal direction stack of configurable depth. On request it replays the solved path one move per cycle. It is the successor of the fixed 16x16 solver and adds configurable grid size and stack depth, a run-time goal, overflow detection and a path length output.

## Interface
- `XW`, 4: x coordinate width.
- `YW`, 4: y coordinate width.
- `XMAX`, 15: largest legal x (inclusive), ≤ 2^XW−1.
- `YMAX`, 15: largest legal y (inclusive), ≤ 2^YW−1.
- `DEPTH`, 256: stack entries; `PW` = clog2(DEPTH+1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a solve; sampled only in IDLE, DONE or FAIL.
- `goal_x` / `goal_y`  in  XW / YW  goal cell; latched when start is accepted.
- `run`  in  1  begin path replay; sampled only in DONE.
- `dout`  in  1  maze cell at (x,y): 1 = wall or visited, 0 = free. Combinational, same cycle.
- `x` / `y`  out  XW / YW  maze memory address.
- `wr`  out  1  memory sets cell (x,y) to 1 at this rising edge.
- `done`  out  1  high while in DONE or REPLAY.
- `fail`  out  1  high while in FAIL.
- `overflow`  out  1  FAIL was caused by a push to a full stack.
- `move`  out  2  replayed direction, valid with `move_valid`.
- `move_valid`  out  1  one replay move per cycle.
- `path_len`  out  PW  current stack pointer (number of moves on the path).

## Operation
- **Directions:** 00 = up (y−1), 01 = right (x+1), 10 = left (x−1), 11 = down (y+1). They are tried in ascending order.
- **Out-of-bounds neighbour:** if the neighbour lies outside 0..XMAX / 0..YMAX, it is treated as a wall. No memory read is relied upon.
- **Registers:** `cur_x`, `cur_y`, probe direction `d` (2 bits), stack pointer `sp`, goal, state.
- **IDLE:** x = y = 0, all outputs 0. When `start` = 1, latch the goal, set cur = (0,0), sp = 0, d = 0, and go to INIT.
- **INIT:** x,y = cur.
  - dout = 1: go to FAIL.
  - Otherwise assert wr.
  - If goal = (0,0), go to DONE; else go to PROBE.
- **PROBE:** x,y = neighbour of cur in direction d.
  - **Free** (in bounds and dout = 0):
    - If sp = DEPTH: set overflow and go to FAIL.
    - Otherwise assert wr, push d, set cur = neighbour and d = 0.
    - If the neighbour is the goal, go to DONE.
  - **Blocked, d < 3:** d = d+1.
  - **Blocked, d = 3:** go to BACK.
- **BACK:** x,y = cur.
  - If sp = 0, go to FAIL.
  - Otherwise pop p and step cur one cell opposite to p.
    - p < 3: d = p+1, go to PROBE.
    - p = 3: stay in BACK.
- **DONE:** x,y = cur and done = 1.
  - `run` takes priority over `start`; it sets the read index r = 0 and goes to REPLAY.
  - If sp = 0, REPLAY returns to DONE immediately with no move_valid.
- **REPLAY:** move = stack[r], move_valid = 1, r = r+1. When r = sp−1, return to DONE. The stack is not modified.
- **FAIL:** fail = 1, x,y = cur. `start` restarts the solve. Overflow is cleared on restart.
- **Reset:** async `rst` in any state (mid-solve or mid-replay) forces IDLE immediately.
  - x, y, wr, done, fail, overflow, move, move_valid and path_len are all 0.
  - Stack contents are undefined.
- **Stack:** `path_len` = sp. Pushes and pops never exceed DEPTH or go below 0.

## Timing
- **One probe per cycle.** Each PROBE cycle either moves, or advances d, or enters BACK.
- **BACK:** each pop costs one cycle.
- **Start latency:** start is sampled at edge E0. INIT occupies E0–E1, and the first PROBE begins after E1.
- **wr:** high only during an INIT or PROBE cycle that accepts a free cell. Address and wr are stable for the whole cycle.
- **Status outputs:** done, fail and overflow are registered state decodes and are valid the cycle after the deciding edge.
- **Replay:** the first move_valid is in the cycle after the edge that samples `run`. Replay produces sp consecutive cycles of move_valid, with no gaps.

## Test plan
Bench memory model: 1 bit per cell, combinational read, set on wr. Tests use XMAX = YMAX = 3 unless noted.

1. **Reset:** assert rst mid-PROBE. All outputs are 0 immediately. After release, the block stays in IDLE without start.
2. **Open grid, goal (3,0):**
   - done rises after edge E7.
   - path_len = 3.
   - run gives move_valid for 3 cycles with move = 01, 01, 01.
   - Cells (0..3,0) are written; wr was high 4 times.
3. **Start walled in:** walls at (1,0) and (0,1), goal (3,3). fail = 1, overflow = 0, path_len = 0, with no wr after INIT.
4. **Backtracking:**
   - Column x = 1 is wall except (1,3); (2,0) is free; goal (2,0).
   - The solver descends x = 0, crosses at y = 3, and climbs x = 2.
   - Replay gives 11, 11, 11, 01, 01, 00, 00, 00. path_len = 8.
5. **Overflow:** DEPTH = 2, open grid, goal (3,3). fail = 1 and overflow = 1 on the third accepted move. path_len = 2.
6. **Restarts:**
   - From DONE, start with goal (0,0): done is reasserted after INIT with path_len = 0.
   - From FAIL, start re-solves normally after the bench clears the memory.
